// File: rtl/ysyx_22050550_hazard_scoreboard_if.sv
// Scoreboard bundle: IDU issue request, WBU retire and flush in; stall/status out.
// master drives the IDU/WBU/flush inputs; slave is the scoreboard itself.
interface ysyx_22050550_hazard_scoreboard_if #(
  parameter int TOT_W = 3
);
  logic             io_IDU_valid;
  logic             io_IDU_ren1;
  logic [4:0]       io_IDU_raddr1;
  logic             io_IDU_ren2;
  logic [4:0]       io_IDU_raddr2;
  logic             io_IDU_wen;
  logic [4:0]       io_IDU_waddr;
  logic             io_IDU_stall;
  logic             io_WBU_valid;
  logic [4:0]       io_WBU_waddr;
  logic             io_flush;
  logic             io_busy;
  logic [TOT_W-1:0] io_inflight;
  logic             io_err;

  modport master (
    output io_IDU_valid, io_IDU_ren1, io_IDU_raddr1,
    output io_IDU_ren2, io_IDU_raddr2,
    output io_IDU_wen, io_IDU_waddr,
    output io_WBU_valid, io_WBU_waddr, io_flush,
    input  io_IDU_stall, io_busy, io_inflight, io_err
  );

  modport slave (
    input  io_IDU_valid, io_IDU_ren1, io_IDU_raddr1,
    input  io_IDU_ren2, io_IDU_raddr2,
    input  io_IDU_wen, io_IDU_waddr,
    input  io_WBU_valid, io_WBU_waddr, io_flush,
    output io_IDU_stall, io_busy, io_inflight, io_err
  );
endinterface

// File: rtl/ysyx_22050550_hazard_scoreboard.sv
// Register scoreboard + issue control: counts in-flight writes per register,
// stalls IDU on uncovered RAW hazards and drains the pipe after a flush.
// Ports: clock, reset (async, active-high), b (slave modport of the bundle).
module ysyx_22050550_hazard_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2,
  parameter int TOT_W = 3
) (
  input logic clock,
  input logic reset,
  ysyx_22050550_hazard_scoreboard_if.slave b
);
  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
  localparam logic [TOT_W-1:0] TMAX = {TOT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt [NREG];
  logic [TOT_W-1:0] r_total;
  logic [0:0]       r_state;
  logic             r_err;

  logic            w_retire;
  logic            w_wr;
  logic            w_hz1;
  logic            w_hz2;
  logic            w_stall;
  logic            w_fire;
  logic            w_inc;
  logic            w_tot_dec;
  logic [NREG-1:0] w_inc_v;
  logic [NREG-1:0] w_dec_v;

  assign w_retire = b.io_WBU_valid && (b.io_WBU_waddr != 5'd0);
  assign w_wr     = b.io_IDU_wen && (b.io_IDU_waddr != 5'd0);

  // The last writer retiring this cycle is forwarded by ByPass, not stalled.
  assign w_hz1 = b.io_IDU_ren1 && (b.io_IDU_raddr1 != 5'd0)
              && (r_cnt[b.io_IDU_raddr1] != '0)
              && !((r_cnt[b.io_IDU_raddr1] == CNT_W'(1)) && w_retire
                   && (b.io_WBU_waddr == b.io_IDU_raddr1));
  assign w_hz2 = b.io_IDU_ren2 && (b.io_IDU_raddr2 != 5'd0)
              && (r_cnt[b.io_IDU_raddr2] != '0)
              && !((r_cnt[b.io_IDU_raddr2] == CNT_W'(1)) && w_retire
                   && (b.io_WBU_waddr == b.io_IDU_raddr2));

  assign w_stall = (r_state == S_DRAIN) || w_hz1 || w_hz2
                || (w_wr && (r_cnt[b.io_IDU_waddr] == CMAX))
                || (r_total == TMAX);

  // Issue during the flush cycle belongs to the squashed path.
  assign w_fire = b.io_IDU_valid && !w_stall && !b.io_flush;
  assign w_inc  = w_fire && w_wr;

  always_comb begin
    w_inc_v = '0;
    w_dec_v = '0;
    if (w_inc)    w_inc_v[b.io_IDU_waddr] = 1'b1;
    if (w_retire) w_dec_v[b.io_WBU_waddr] = 1'b1;
  end

  // Total follows the per-register rule: a retire of an idle register
  // only counts if a same-cycle issue to it cancels out.
  assign w_tot_dec = w_retire
                  && ((r_cnt[b.io_WBU_waddr] != '0)
                      || w_inc_v[b.io_WBU_waddr]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (w_inc_v[r] && !w_dec_v[r])
          r_cnt[r] <= r_cnt[r] + 1'b1;
        else if (w_dec_v[r] && !w_inc_v[r] && (r_cnt[r] != '0))
          r_cnt[r] <= r_cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_total <= '0;
    end else if (w_inc && !w_tot_dec) begin
      r_total <= r_total + 1'b1;
    end else if (w_tot_dec && !w_inc) begin
      r_total <= r_total - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_retire && (r_cnt[b.io_WBU_waddr] == '0)) begin
      r_err <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_RUN;
    end else begin
      unique case (r_state)
        S_RUN:   if (b.io_flush) r_state <= S_DRAIN;
        S_DRAIN: if (!b.io_flush && (r_total == '0)) r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign b.io_IDU_stall = w_stall;
  assign b.io_busy      = (r_state == S_DRAIN);
  assign b.io_inflight  = r_total;
  assign b.io_err       = r_err;
endmodule
